// File: rtl/data_mem_256_if.sv
// Cache-side request/response bundle for the 256-bit line data memory.
// The master (cache) holds a request until the slave pulses ack_o.
interface data_mem_256_if #(
   parameter int LINE_BITS = 256
);
   logic [31:0]          addr_i;
   logic [LINE_BITS-1:0] data_i;
   logic                 enable_i;
   logic                 write_i;
   logic                 ack_o;
   logic [LINE_BITS-1:0] data_o;

   modport master (
      output addr_i, data_i, enable_i, write_i,
      input  ack_o, data_o
   );

   modport slave (
      input  addr_i, data_i, enable_i, write_i,
      output ack_o, data_o
   );
endinterface

// File: rtl/data_mem_256.sv
// data_mem_256: 512 x 256-bit line memory with fixed latency and one-cycle ack.
// Option DMEM_ADDR_CHECK_EN: nonzero addr[31:14] reads zeros, drops writes.
module data_mem_256 #(
   parameter int MEM_LATENCY = 10,
   parameter int LINE_BITS   = 256,
   parameter int DEPTH       = 512
) (
   input logic           clk_i,
   input logic           rst_i,
   data_mem_256_if.slave bus
);
   localparam int CW = $clog2(MEM_LATENCY);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t               state;
   logic [CW-1:0]        count;
   logic [LINE_BITS-1:0] data;
   logic [LINE_BITS-1:0] memory [0:DEPTH-1];

   logic [8:0] idx;
   logic       last;
   logic       pre_last;
   logic       addr_ok;
   logic       unused_bits;

   assign idx = bus.addr_i[13:5];
   assign unused_bits = ^{bus.addr_i[31:14], bus.addr_i[4:0]};

`ifdef DMEM_ADDR_CHECK_EN
   assign addr_ok = ~|bus.addr_i[31:14];
`else
   assign addr_ok = 1'b1;
`endif

   assign last = (state == S_WAIT)
              && (count == CW'(MEM_LATENCY - 1));
   assign pre_last = (state == S_WAIT)
                  && (count == CW'(MEM_LATENCY - 2));

   assign bus.ack_o  = last;
   assign bus.data_o = data;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= S_IDLE;
         count <= '0;
         data  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.enable_i) begin
                  state <= S_WAIT;
                  count <= '0;
               end
            end
            S_WAIT: begin
               if (last) begin
                  state <= S_IDLE;
                  count <= '0;
               end else begin
                  count <= count + CW'(1);
               end
               // read data lands as ack rises, so it is stable for the ack cycle
               if (pre_last && !bus.write_i) begin
                  data <= addr_ok ? memory[idx] : '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // contents survive reset; a write only lands on the edge closing ack
   always_ff @(posedge clk_i) begin
      if (last && bus.write_i && addr_ok) begin
         memory[idx] <= bus.data_i;
      end
   end
endmodule

// File: tb/tb_data_mem_256.sv
// Self-checking bench for data_mem_256 against an array model of the memory.
// Latency counted as cycles starting with the one after the accepting edge.
module tb_data_mem_256;
   localparam int LAT = 10;

   logic clk_i;
   logic rst_i;
   int   n_checks;
   int   n_fail;

   logic [255:0] ref_mem [0:511];

   data_mem_256_if bus ();

   data_mem_256 dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [255:0] rand_line();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [255:0] exp_read(input logic [31:0] a);
`ifdef DMEM_ADDR_CHECK_EN
      if (a[31:14] != 18'd0) return '0;
`endif
      return ref_mem[a[13:5]];
   endfunction

   function automatic void model_write(input logic [31:0] a,
                                       input logic [255:0] d);
`ifdef DMEM_ADDR_CHECK_EN
      if (a[31:14] != 18'd0) return;
`endif
      ref_mem[a[13:5]] = d;
   endfunction

   // precondition: called #1 after a posedge with the DUT idle
   task automatic run_txn(input logic wr, input logic [31:0] a,
                          input logic [255:0] d, output int lat,
                          output logic [255:0] rd, output logic ack_next);
      bus.enable_i = 1'b1;
      bus.write_i  = wr;
      bus.addr_i   = a;
      bus.data_i   = d;
      lat = 0;
      do begin
         @(posedge clk_i); #1;
         lat++;
      end while (!bus.ack_o && lat < 40);
      rd = bus.data_o;
      bus.enable_i = 1'b0;
      @(posedge clk_i); #1;
      ack_next = bus.ack_o;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      n_checks++;
      if (bus.ack_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ack: got %b want 0", bus.ack_o);
      end
      n_checks++;
      if (bus.data_o !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got %h want 0", bus.data_o);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
   endtask

   task automatic test_read_preload();
      logic [255:0] line, rd;
      int lat;
      logic an;
      for (int i = 0; i < 16; i++) line[(15 - i)*16 +: 16] = 16'(i) * 16'h1111;
      ref_mem[0] = line;
      dut.memory[0] = line;
      run_txn(1'b0, 32'h0, '0, lat, rd, an);
      n_checks++;
      if (lat != LAT) begin
         n_fail++;
         $display("FAIL preload_latency: got %0d want %0d", lat, LAT);
      end
      n_checks++;
      if (rd !== line) begin
         n_fail++;
         $display("FAIL preload_data: got %h want %h", rd, line);
      end
      n_checks++;
      if (an !== 1'b0) begin
         n_fail++;
         $display("FAIL preload_ack_drop: got %b want 0", an);
      end
   endtask

   task automatic test_write_read();
      logic [255:0] wline, old, rd;
      int lat;
      logic an;
      wline = {8{32'hDEADBEEF}};
      old = ref_mem[17];
      bus.enable_i = 1'b1;
      bus.write_i  = 1'b1;
      bus.addr_i   = 32'h220;
      bus.data_i   = wline;
      lat = 0;
      do begin
         @(posedge clk_i); #1;
         lat++;
      end while (!bus.ack_o && lat < 40);
      n_checks++;
      if (lat != LAT) begin
         n_fail++;
         $display("FAIL write_latency: got %0d want %0d", lat, LAT);
      end
      n_checks++;
      if (dut.memory[17] !== old) begin
         n_fail++;
         $display("FAIL write_early: got %h want %h", dut.memory[17], old);
      end
      bus.enable_i = 1'b0;
      @(posedge clk_i); #1;
      model_write(32'h220, wline);
      n_checks++;
      if (dut.memory[17] !== wline) begin
         n_fail++;
         $display("FAIL write_commit: got %h want %h", dut.memory[17], wline);
      end
      run_txn(1'b0, 32'h220, '0, lat, rd, an);
      n_checks++;
      if (rd !== exp_read(32'h220)) begin
         n_fail++;
         $display("FAIL write_readback: got %h want %h", rd, exp_read(32'h220));
      end
   endtask

   task automatic test_offset();
      logic [255:0] rd;
      int lat;
      logic an;
      run_txn(1'b0, 32'h3F, '0, lat, rd, an);
      n_checks++;
      if (rd !== ref_mem[1]) begin
         n_fail++;
         $display("FAIL offset_read: got %h want %h", rd, ref_mem[1]);
      end
   endtask

   task automatic test_reset_mid();
      int acks;
      bus.enable_i = 1'b1;
      bus.write_i  = 1'b1;
      bus.addr_i   = 32'h40;
      bus.data_i   = ~ref_mem[2];
      @(posedge clk_i);
      repeat (5) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      #1;
      n_checks++;
      if (bus.ack_o !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_ack: got %b want 0", bus.ack_o);
      end
      n_checks++;
      if (bus.data_o !== '0) begin
         n_fail++;
         $display("FAIL midreset_data: got %h want 0", bus.data_o);
      end
      bus.enable_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
      acks = 0;
      for (int c = 0; c < 14; c++) begin
         @(posedge clk_i); #1;
         if (bus.ack_o) acks++;
      end
      n_checks++;
      if (acks != 0) begin
         n_fail++;
         $display("FAIL midreset_noack: got %0d acks want 0", acks);
      end
      n_checks++;
      if (dut.memory[2] !== ref_mem[2]) begin
         n_fail++;
         $display("FAIL midreset_mem: got %h want %h", dut.memory[2], ref_mem[2]);
      end
   endtask

   task automatic test_back_to_back();
      logic [255:0] rd;
      int lat, lat2;
      logic an;
      run_txn(1'b0, 32'h0000_0100, '0, lat, rd, an);
      run_txn(1'b0, 32'h0000_0120, '0, lat, rd, an);
      n_checks++;
      if (lat != LAT || rd !== exp_read(32'h120)) begin
         n_fail++;
         $display("FAIL b2b_reraise: got lat %0d data %h want lat %0d data %h",
                  lat, rd, LAT, exp_read(32'h120));
      end
      bus.enable_i = 1'b1;
      bus.write_i  = 1'b0;
      bus.addr_i   = 32'h0000_0140;
      lat = 0;
      do begin
         @(posedge clk_i); #1;
         lat++;
      end while (!bus.ack_o && lat < 40);
      n_checks++;
      if (lat != LAT || bus.data_o !== exp_read(32'h140)) begin
         n_fail++;
         $display("FAIL b2b_held_first: got lat %0d data %h want lat %0d",
                  lat, bus.data_o, LAT);
      end
      bus.addr_i = 32'h0000_0160;
      @(posedge clk_i); #1;
      n_checks++;
      if (bus.ack_o !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle_gap: got ack %b want 0", bus.ack_o);
      end
      lat2 = 0;
      do begin
         @(posedge clk_i); #1;
         lat2++;
      end while (!bus.ack_o && lat2 < 40);
      n_checks++;
      if (lat2 != LAT || bus.data_o !== exp_read(32'h160)) begin
         n_fail++;
         $display("FAIL b2b_held_second: got lat %0d data %h want lat %0d data %h",
                  lat2, bus.data_o, LAT, exp_read(32'h160));
      end
      bus.enable_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_addr_alias();
      logic [255:0] rd, want;
      int lat;
      logic an;
`ifdef DMEM_ADDR_CHECK_EN
      want = '0;
`else
      want = ref_mem[0];
`endif
      run_txn(1'b0, 32'h0001_0000, '0, lat, rd, an);
      n_checks++;
      if (rd !== want || lat != LAT) begin
         n_fail++;
         $display("FAIL alias_read: got %h lat %0d want %h lat %0d",
                  rd, lat, want, LAT);
      end
   endtask

   task automatic test_random();
      logic [255:0] rd, d;
      logic [31:0] a;
      logic wr, an;
      int lat;
      for (int t = 0; t < 40; t++) begin
         wr = 1'($urandom_range(0, 1));
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[31:14] = '0;
         a[13:5] = 9'($urandom_range(0, 15));
         d = rand_line();
         run_txn(wr, a, d, lat, rd, an);
         n_checks++;
         if (lat != LAT || an !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_timing[%0d]: got lat %0d ack_after %b want %0d 0",
                     t, lat, an, LAT);
         end
         if (wr) begin
            model_write(a, d);
         end else begin
            n_checks++;
            if (rd !== exp_read(a)) begin
               n_fail++;
               $display("FAIL rand_read[%0d] addr %h: got %h want %h",
                        t, a, rd, exp_read(a));
            end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      rst_i = 1'b0;
      bus.enable_i = 1'b0;
      bus.write_i  = 1'b0;
      bus.addr_i   = '0;
      bus.data_i   = '0;
      for (int i = 0; i < 512; i++) begin
         ref_mem[i] = rand_line();
         dut.memory[i] = ref_mem[i];
      end
      test_reset();
      test_read_preload();
      test_write_read();
      test_offset();
      test_reset_mid();
      test_back_to_back();
      test_addr_alias();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
